// File: rtl/gen_worker_axil_regfile.sv
// AXI4-Lite register file for the generation worker: CTRL/START, sticky DONE
// with interrupt, read-only generation counter and byte-strobed parameter regs.
module gen_worker_axil_regfile #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_NUM_REGS         = 16
) (
    input  logic                                              s00_axi_aclk,
    input  logic                                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                     s00_axi_awaddr,
    input  logic [2:0]                                        s00_axi_awprot,
    input  logic                                              s00_axi_awvalid,
    output logic                                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                   s00_axi_wstrb,
    input  logic                                              s00_axi_wvalid,
    output logic                                              s00_axi_wready,
    output logic [1:0]                                        s00_axi_bresp,
    output logic                                              s00_axi_bvalid,
    input  logic                                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                     s00_axi_araddr,
    input  logic [2:0]                                        s00_axi_arprot,
    input  logic                                              s00_axi_arvalid,
    output logic                                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                     s00_axi_rdata,
    output logic [1:0]                                        s00_axi_rresp,
    output logic                                              s00_axi_rvalid,
    input  logic                                              s00_axi_rready,
    output logic                                              start_pulse,
    input  logic                                              busy_in,
    input  logic                                              done_in,
    output logic                                              irq,
    output logic [(C_NUM_REGS-3)*C_S_AXI_DATA_WIDTH-1:0]      params
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned NR       = C_NUM_REGS;
    localparam int unsigned STRB_W   = DW / 8;
    localparam int unsigned ADDR_LSB = (DW == 64) ? 3 : 2;
    localparam int unsigned IDX_W    = AW - ADDR_LSB;
    localparam int unsigned PW       = (NR - 3) * DW;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic              aw_held;
    logic              w_held;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [DW-1:0]     wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              irq_en_q;
    logic              done_q;
    logic [DW-1:0]     gen_count_q;
    logic [PW-1:0]     params_q;

    logic              wr_fire_c;
    logic              wr_in_range_c;
    logic              w1c_done_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic              rd_in_range_c;
    logic [DW-1:0]     rd_mux_c;

    // Protection bits and sub-word address bits carry no meaning here
    logic unused_sig;
    assign unused_sig = ^{s00_axi_awprot, s00_axi_arprot,
                          s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

    assign params = params_q;

    // Write commit strobe and decode of the held write
    always_comb begin
        wr_fire_c     = aw_held & w_held & ~s00_axi_bvalid;
        wr_in_range_c = (32'(wr_idx_q) < NR);
        w1c_done_c    = wr_fire_c & wr_in_range_c & (wr_idx_q == IDX_W'(1))
                        & wstrb_q[0] & wdata_q[1];
    end

    // Write address channel: one-cycle ready pulse, hold until B completes
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            aw_held         <= 1'b0;
            wr_idx_q        <= '0;
        end else begin
            s00_axi_awready <= s00_axi_awvalid & ~s00_axi_awready & ~aw_held & ~s00_axi_bvalid;
            if (s00_axi_awvalid && s00_axi_awready) begin
                aw_held  <= 1'b1;
                wr_idx_q <= s00_axi_awaddr[AW-1:ADDR_LSB];
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                aw_held <= 1'b0;
            end
        end
    end

    // Write data channel: one-cycle ready pulse, hold until B completes
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_wready <= 1'b0;
            w_held         <= 1'b0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
        end else begin
            s00_axi_wready <= s00_axi_wvalid & ~s00_axi_wready & ~w_held & ~s00_axi_bvalid;
            if (s00_axi_wvalid && s00_axi_wready) begin
                w_held  <= 1'b1;
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                w_held <= 1'b0;
            end
        end
    end

    // Write response: raised on commit, held until bready
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp  <= RESP_OKAY;
        end else if (wr_fire_c) begin
            s00_axi_bvalid <= 1'b1;
            s00_axi_bresp  <= wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else if (s00_axi_bvalid && s00_axi_bready) begin
            s00_axi_bvalid <= 1'b0;
        end
    end

    // Register state: CTRL, START pulse, parameter bytes, DONE, counter, irq
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            start_pulse <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            gen_count_q <= '0;
            params_q    <= '0;
            irq         <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (wr_fire_c && wr_in_range_c) begin
                if (wr_idx_q == IDX_W'(0) && wstrb_q[0]) begin
                    start_pulse <= wdata_q[0];
                    irq_en_q    <= wdata_q[1];
                end
                for (int unsigned r = 3; r < NR; r++) begin
                    if (wr_idx_q == IDX_W'(r)) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if (wstrb_q[b]) begin
                                params_q[(r-3)*DW + b*8 +: 8] <= wdata_q[b*8 +: 8];
                            end
                        end
                    end
                end
            end
            // Engine completion beats a coincident W1C
            if (done_in) begin
                done_q <= 1'b1;
            end else if (w1c_done_c) begin
                done_q <= 1'b0;
            end
            if (done_in) begin
                gen_count_q <= gen_count_q + DW'(1);
            end
            irq <= done_q & irq_en_q;
        end
    end

    // Read data selection from the presented read address
    always_comb begin
        rd_idx_c      = s00_axi_araddr[AW-1:ADDR_LSB];
        rd_in_range_c = (32'(rd_idx_c) < NR);
        rd_mux_c      = '0;
        if (rd_in_range_c) begin
            if (rd_idx_c == IDX_W'(0)) begin
                rd_mux_c[1] = irq_en_q;
            end else if (rd_idx_c == IDX_W'(1)) begin
                rd_mux_c[0] = busy_in;
                rd_mux_c[1] = done_q;
            end else if (rd_idx_c == IDX_W'(2)) begin
                rd_mux_c = gen_count_q;
            end else begin
                for (int unsigned r = 3; r < NR; r++) begin
                    if (rd_idx_c == IDX_W'(r)) begin
                        rd_mux_c = params_q[(r-3)*DW +: DW];
                    end
                end
            end
        end
    end

    // Read channel: accept one read at a time, hold data until rready
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            s00_axi_arready <= s00_axi_arvalid & ~s00_axi_arready & ~s00_axi_rvalid;
            if (s00_axi_arvalid && s00_axi_arready) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux_c;
                s00_axi_rresp  <= rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gen_worker_axil_regfile.sv
// Directed bench for gen_worker_axil_regfile (32-bit data, 16 regs, 7-bit address
// so that 0x40 is a genuine out-of-range index).
module tb_gen_worker_axil_regfile;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 7;
    localparam int unsigned NR = 16;
    localparam int unsigned PW = (NR - 3) * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          start_pulse, busy_in, done_in, irq;
    logic [PW-1:0] params;

    int checks = 0;
    int fails  = 0;
    int start_cnt = 0;

    gen_worker_axil_regfile #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_NUM_REGS(NR)
    ) dut (
        .s00_axi_aclk(clk),       .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid),  .s00_axi_rready(rready),
        .start_pulse(start_pulse), .busy_in(busy_in), .done_in(done_in),
        .irq(irq),                .params(params)
    );

    always #5 clk = ~clk;

    // Counts cycles in which start_pulse is high
    always @(negedge clk) if (start_pulse) start_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit ad = 0, wd = 0, ahs, whs;
        int t = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(ad && wd) && t < 20) begin
            ahs = awvalid && awready;
            whs = wvalid && wready;
            tick();
            if (ahs) begin awvalid = 1'b0; ad = 1; end
            if (whs) begin wvalid = 1'b0; wd = 1; end
            t++;
        end
        chk("wr_accept", {62'b0, ad, wd}, 64'h3);
        t = 0;
        while (!bvalid && t < 20) begin tick(); t++; end
        chk("wr_bvalid", 64'(bvalid), 64'h1);
        resp = bresp;
        tick();
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic [1:0] resp);
        int t = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        while (!arready && t < 20) begin tick(); t++; end
        chk("rd_arready", 64'(arready), 64'h1);
        tick();
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 20) begin tick(); t++; end
        chk("rd_rvalid", 64'(rvalid), 64'h1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]    resp;
        logic [DW-1:0] d;
        int            sc;
        int            t;

        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0; busy_in = 0; done_in = 0;
        repeat (3) tick();
        chk("rst_readies", {60'b0, awready, wready, arready, start_pulse}, 64'h0);
        chk("rst_valids", {59'b0, bvalid, rvalid, bresp, irq}, 64'h0);
        chk("rst_rdata", {30'b0, rresp, rdata}, 64'h0);
        chk("rst_params", 64'(params[63:0]), 64'h0);
        rst_n = 1'b1;
        tick();

        // Parameter registers 3..6
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(12 + 4*i), DW'(i + 1), 4'hF, resp);
            chk("param_wr_resp", 64'(resp), 64'h0);
        end
        chk("params_lsw", 64'(params[31:0]), 64'h1);
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(12 + 4*i), d, resp);
            chk("param_rd_data", 64'(d), 64'(i + 1));
            chk("param_rd_resp", 64'(resp), 64'h0);
        end

        // Byte strobes
        axi_write(7'h0C, 32'hAABBCCDD, 4'b0101, resp);
        axi_read(7'h0C, d, resp);
        chk("strobe_rd", 64'(d), 64'h00BB00DD);

        // START pulse and IRQ_EN
        sc = start_cnt;
        axi_write(7'h00, 32'h3, 4'hF, resp);
        repeat (3) tick();
        chk("start_cycles", 64'(start_cnt - sc), 64'h1);
        axi_read(7'h00, d, resp);
        chk("ctrl_rd", 64'(d), 64'h2);
        chk("irq_idle", 64'(irq), 64'h0);

        // DONE set and irq lag
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("irq_lag", 64'(irq), 64'h0);
        tick();
        chk("irq_high", 64'(irq), 64'h1);
        axi_read(7'h04, d, resp);
        chk("status_done", 64'(d), 64'h2);
        axi_read(7'h08, d, resp);
        chk("gen_count_1", 64'(d), 64'h1);

        // W1C of DONE
        axi_write(7'h04, 32'h2, 4'hF, resp);
        chk("w1c_resp", 64'(resp), 64'h0);
        chk("irq_fall", 64'(irq), 64'h0);
        axi_read(7'h04, d, resp);
        chk("status_clr", 64'(d), 64'h0);

        // W1C coincident with done_in: set wins
        done_in = 1'b1; tick(); done_in = 1'b0; tick();
        awaddr = 7'h04; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        chk("coin_awready", 64'(awready), 64'h1);
        chk("coin_wready", 64'(wready), 64'h1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("coin_bvalid", 64'(bvalid), 64'h1);
        bready = 1'b1; tick(); bready = 1'b0;
        axi_read(7'h04, d, resp);
        chk("coin_status", 64'(d), 64'h2);
        axi_read(7'h08, d, resp);
        chk("coin_gen_count", 64'(d), 64'h3);

        // Out-of-range index
        axi_write(7'h40, 32'h12345670, 4'hF, resp);
        chk("oor_bresp", 64'(resp), 64'h2);
        axi_read(7'h40, d, resp);
        chk("oor_rdata", 64'(d), 64'h0);
        chk("oor_rresp", 64'(resp), 64'h2);
        axi_read(7'h00, d, resp);
        chk("oor_ctrl_kept", 64'(d), 64'h2);
        axi_read(7'h0C, d, resp);
        chk("oor_reg3_kept", 64'(d), 64'h00BB00DD);

        // W ahead of AW, bready held low, second AW waits
        awaddr = 7'h10; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        tick();
        chk("early_wready", 64'(wready), 64'h1);
        chk("early_awready", 64'(awready), 64'h0);
        tick();
        wvalid = 1'b0;
        tick();
        chk("wready_held", 64'(wready), 64'h0);
        awvalid = 1'b1;
        tick();
        chk("late_awready", 64'(awready), 64'h1);
        tick();
        awvalid = 1'b0;
        tick();
        chk("late_bvalid", 64'(bvalid), 64'h1);
        awaddr = 7'h14; wdata = 32'h66; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bvalid_hold", {61'b0, bvalid, awready, wready}, 64'h4);
            tick();
        end
        bready = 1'b1; tick(); bready = 1'b0;
        chk("bvalid_drop", 64'(bvalid), 64'h0);
        axi_write(7'h14, 32'h66, 4'hF, resp);
        chk("second_wr_resp", 64'(resp), 64'h0);
        axi_read(7'h10, d, resp);
        chk("reg4_rd", 64'(d), 64'h55);
        axi_read(7'h14, d, resp);
        chk("reg5_rd", 64'(d), 64'h66);

        // Asynchronous reset in the middle of a read
        araddr = 7'h0C; arvalid = 1'b1; rready = 1'b0;
        t = 0;
        while (!arready && t < 20) begin tick(); t++; end
        chk("mid_arready", 64'(arready), 64'h1);
        tick();
        arvalid = 1'b0;
        chk("mid_rvalid", 64'(rvalid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rvalid", 64'(rvalid), 64'h0);
        chk("async_params", 64'(params[63:0]), 64'h0);
        chk("async_irq", 64'(irq), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            axi_read(AW'(4*i), d, resp);
            chk("post_rst_reg", 64'(d), 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gen_worker_axil_regfile.md
Name: gen_worker_axil_regfile

Overview:
Parametrised AXI4-Lite slave register file for the generation worker. It replaces the fixed four-register slave with a configurable register count and data width. It adds byte strobes, SLVERR on out-of-range accesses, a self-clearing start pulse, a sticky write-1-to-clear DONE flag with an interrupt, and a read-only generation counter. It sits between the PS AXI interconnect and the generation engine core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^ADDR_WIDTH >= C_NUM_REGS*(DATA_WIDTH/8).
C_NUM_REGS, 16, register count; minimum 4.

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  write address handshake
s00_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data
s00_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte strobes
s00_axi_wvalid / s00_axi_wready  in/out  1  write data handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid / s00_axi_bready  out/in  1  write response handshake
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  read address handshake
s00_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out/in  1  read data handshake
start_pulse  out  1  one-cycle start to the engine
busy_in  in  1  engine busy level
done_in  in  1  engine done pulse
irq  out  1  level interrupt = DONE & IRQ_EN
params  out  (C_NUM_REGS-3)*C_S_AXI_DATA_WIDTH  registers 3..N-1 flattened, register 3 in the LSBs

Behaviour:
- Reset: all ready/valid outputs, bresp, rresp, rdata, start_pulse, irq and all registers are 0. Reset is asynchronous; any in-flight transaction is dropped.
- Register index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; the low address bits are ignored.
- Register map:
  - reg0 CTRL: bit0 START, bit1 IRQ_EN, other bits reserved and read 0.
  - reg1 STATUS: bit0 BUSY (read-only, reflects busy_in), bit1 DONE (sticky, W1C).
  - reg2 GEN_COUNT: read-only. Increments by 1 on each done_in cycle and wraps from all-ones to 0.
  - reg3..N-1: read/write, byte-strobed.
- Write channel:
  - AW and W are accepted independently; each ready pulses for one cycle on its handshake.
  - Once either half is captured, that channel's ready stays low until the B handshake completes. Only one write is outstanding.
  - The register update and bvalid assertion occur in the cycle after both halves are held.
  - bvalid holds until bready is sampled high.
- Read channel:
  - arready pulses one cycle when arvalid is high, rvalid is low, and no read is pending.
  - rvalid asserts the next cycle with rdata registered, and holds (rdata stable) until rready.
- Out-of-range index (>= C_NUM_REGS): the write is discarded and the read returns 0, both with resp 2'b10 (SLVERR). All other accesses return 2'b00.
- Writes to read-only fields: the data is ignored and the response is OKAY.
- START:
  - Writing CTRL with bit0 = 1 (strobe on byte 0) drives start_pulse high for exactly one cycle, the cycle after the write commits.
  - The START bit always reads 0.
  - A START write while busy_in = 1 still pulses; the engine ignores it.
- DONE:
  - done_in sets DONE.
  - W1C to DONE clears it.
  - If done_in and a W1C land in the same cycle, the set wins.
- irq is registered: it follows DONE & IRQ_EN with a one-cycle lag.
- params updates in the cycle after the write commits.
- Simultaneous read and write to the same register: the read returns the pre-write value if AR is accepted in or before the commit cycle.

Test Plan:
- Defaults (DATA_WIDTH=32, NUM_REGS=16). Write 0x1,0x2,0x3,0x4 to regs 3..6 at addresses 0x0C..0x18, then read back -> 0x1..0x4 with OKAY; params[31:0] = 0x1.
- Write 0xAABBCCDD to reg3 with wstrb = 4'b0101 over the prior value 0x00000001 -> reads back 0x00BB00DD.
- Write CTRL = 0x3 -> start_pulse high for exactly one cycle. Then pulse done_in once -> STATUS reads 0x2, GEN_COUNT reads 1, irq is high one cycle later. Write STATUS = 0x2 -> DONE = 0 and irq falls.
- W1C of DONE coincident with a done_in pulse -> DONE stays 1 and GEN_COUNT increments.
- Write to 0x40 with NUM_REGS=16 -> bresp = 2'b10 and no register changes. Read of 0x40 -> rdata = 0, rresp = 2'b10.
- W presented 3 cycles before AW, with bready held low 4 cycles -> bvalid holds, awready/wready stay low, and a second AW waits. Assert reset mid-read -> rvalid drops asynchronously and all registers read 0 afterwards.
